// File: rtl/sha256_msg_ctrl.sv
// sha256_msg_ctrl: byte-stream front end for a sha256 compression core.
// Packs message bytes into 512-bit blocks and applies SHA-256 padding.
// It issues one block at a time to the core and chains the core result
// into the next block. The final digest is presented on a valid/ready port.
//
// state | meaning
// FILL  | accepting message bytes into the block buffer
// SEND  | in_vld pulse, chunk = buffer, in_hash = H
// WAIT  | block outstanding at the core, chunk/in_hash held
// PAD2  | build the trailing padding-only block
// OUT   | digest presented until accepted
module sha256_msg_ctrl #(
    parameter int LEN_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [7:0]     s_data,
    input  logic           s_valid,
    input  logic           s_last,
    output logic           s_ready,
    output logic [511:0]   chunk,
    output logic [255:0]   in_hash,
    output logic           in_vld,
    input  logic [255:0]   out_hash,
    input  logic           out_vld,
    output logic [255:0]   m_digest,
    output logic           m_valid,
    input  logic           m_ready
);

    localparam logic [255:0] IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                   32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

    typedef enum logic [2:0] {ST_FILL, ST_SEND, ST_WAIT, ST_PAD2, ST_OUT} state_t;

    state_t             state_q, state_d;
    logic [5:0]         idx_q, idx_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [511:0]       buf_q, buf_d;
    logic [255:0]       h_q, h_d;
    logic               final_q, final_d;
    logic               pad_pending_q, pad_pending_d;
    logic               pad_80_q, pad_80_d;
    logic               in_vld_q, in_vld_d;
    logic               s_ready_q, s_ready_d;
    logic               m_valid_q, m_valid_d;
    logic [255:0]       m_digest_q, m_digest_d;

    logic [6:0]         n_fill;
    logic [LEN_W-1:0]   cnt_inc;
    logic [63:0]        fill_len;
    logic [63:0]        pad_len;

    // Block byte j lands in word j/4, big-endian within the word.
    function automatic int byte_lsb(input int j);
        return 32 * (j / 4) + 8 * (3 - (j % 4));
    endfunction

    // Next-state, buffer packing/padding and output computation.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        buf_d         = buf_q;
        h_d           = h_q;
        final_d       = final_q;
        pad_pending_d = pad_pending_q;
        pad_80_d      = pad_80_q;
        m_valid_d     = m_valid_q;
        m_digest_d    = m_digest_q;

        n_fill   = {1'b0, idx_q} + 7'd1;
        cnt_inc  = cnt_q + LEN_W'(1);
        fill_len = 64'(cnt_inc) << 3;
        pad_len  = 64'(cnt_q) << 3;

        case (state_q)
            ST_FILL: begin
                if (s_valid && s_ready_q) begin
                    cnt_d = cnt_inc;
                    idx_d = n_fill[5:0];
                    for (int j = 0; j < 64; j++) begin
                        if (7'(j) == {1'b0, idx_q}) begin
                            buf_d[byte_lsb(j) +: 8] = s_data;
                        end else if (s_last && 7'(j) == n_fill) begin
                            buf_d[byte_lsb(j) +: 8] = 8'h80;
                        end else if (s_last && 7'(j) > n_fill) begin
                            // Length field only fits when the message ended early enough.
                            if (n_fill <= 7'd55 && j >= 56) begin
                                buf_d[byte_lsb(j) +: 8] = fill_len[8 * (63 - j) +: 8];
                            end else begin
                                buf_d[byte_lsb(j) +: 8] = 8'h00;
                            end
                        end
                    end
                    if (s_last || n_fill == 7'd64) begin
                        state_d       = ST_SEND;
                        final_d       = s_last && (n_fill <= 7'd55);
                        pad_pending_d = s_last && (n_fill > 7'd55);
                        pad_80_d      = s_last && (n_fill == 7'd64);
                    end
                end
            end
            ST_SEND: begin
                idx_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (out_vld) begin
                    h_d = out_hash;
                    if (final_q) begin
                        state_d    = ST_OUT;
                        m_valid_d  = 1'b1;
                        m_digest_d = out_hash;
                    end else if (pad_pending_q) begin
                        state_d = ST_PAD2;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_PAD2: begin
                buf_d = '0;
                if (pad_80_q) begin
                    buf_d[31:24] = 8'h80;
                end
                for (int j = 56; j < 64; j++) begin
                    buf_d[byte_lsb(j) +: 8] = pad_len[8 * (63 - j) +: 8];
                end
                final_d       = 1'b1;
                pad_pending_d = 1'b0;
                pad_80_d      = 1'b0;
                state_d       = ST_SEND;
            end
            ST_OUT: begin
                if (m_ready) begin
                    h_d       = IV;
                    cnt_d     = '0;
                    idx_d     = '0;
                    m_valid_d = 1'b0;
                    state_d   = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase

        in_vld_d  = (state_d == ST_SEND);
        s_ready_d = (state_d == ST_FILL);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_FILL;
            idx_q         <= '0;
            cnt_q         <= '0;
            buf_q         <= '0;
            h_q           <= IV;
            final_q       <= 1'b0;
            pad_pending_q <= 1'b0;
            pad_80_q      <= 1'b0;
            in_vld_q      <= 1'b0;
            s_ready_q     <= 1'b0;
            m_valid_q     <= 1'b0;
            m_digest_q    <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            buf_q         <= buf_d;
            h_q           <= h_d;
            final_q       <= final_d;
            pad_pending_q <= pad_pending_d;
            pad_80_q      <= pad_80_d;
            in_vld_q      <= in_vld_d;
            s_ready_q     <= s_ready_d;
            m_valid_q     <= m_valid_d;
            m_digest_q    <= m_digest_d;
        end
    end

    assign chunk    = buf_q;
    assign in_hash  = h_q;
    assign in_vld   = in_vld_q;
    assign s_ready  = s_ready_q;
    assign m_valid  = m_valid_q;
    assign m_digest = m_digest_q;

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Testbench for sha256_msg_ctrl: behavioural sha256 core responder plus a
// software SHA-256 reference feeding a digest scoreboard.
module tb_sha256_msg_ctrl;

    typedef logic [7:0] bytes_t[$];

    localparam logic [255:0] IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                   32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic         clk;
    logic         rst_n;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic [511:0] chunk;
    logic [255:0] in_hash;
    logic         in_vld;
    logic [255:0] out_hash;
    logic         out_vld;
    logic [255:0] m_digest;
    logic         m_valid;
    logic         m_ready;

    int n_vec = 0;
    int n_err = 0;

    logic [255:0] exp_q[$];
    logic [511:0] chunk_log[$];
    int           pulse_cnt = 0;
    logic [255:0] got_digest;

    bit           core_busy = 0;
    int           core_lat_cnt = 0;
    int           core_lat_min = 0;
    int           core_lat_max = 3;
    logic [255:0] core_res;

    sha256_msg_ctrl #(.LEN_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .chunk    (chunk),
        .in_hash  (in_hash),
        .in_vld   (in_vld),
        .out_hash (out_hash),
        .out_vld  (out_vld),
        .m_digest (m_digest),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[32 * i +: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        a = hin[31:0];    b = hin[63:32];   c = hin[95:64];   d = hin[127:96];
        e = hin[159:128]; f = hin[191:160]; g = hin[223:192]; hh = hin[255:224];
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hh + hin[255:224], g + hin[223:192], f + hin[191:160], e + hin[159:128],
                d + hin[127:96], c + hin[95:64], b + hin[63:32], a + hin[31:0]};
    endfunction

    // Reference SHA-256 over a whole message (own padding, own block split).
    function automatic logic [255:0] sha256_model(input bytes_t msg);
        bytes_t       p;
        logic [63:0]  bl;
        logic [511:0] blk;
        logic [255:0] h;
        p = msg;
        bl = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[8 * i +: 8]);
        h = IV;
        for (int bi = 0; bi < p.size() / 64; bi++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk[32 * (j / 4) + 8 * (3 - (j % 4)) +: 8] = p[bi * 64 + j];
            h = sha_compress(h, blk);
        end
        return h;
    endfunction

    function automatic bytes_t rand_msg(input int len);
        bytes_t q;
        for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    function automatic bytes_t str_msg(input string s);
        bytes_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Behavioural sha256 core: captures a block on in_vld, answers after a random latency.
    always @(negedge clk) begin
        out_vld = 1'b0;
        if (core_busy) begin
            if (core_lat_cnt == 0) begin
                out_vld   = 1'b1;
                out_hash  = core_res;
                core_busy = 0;
            end else begin
                core_lat_cnt--;
            end
        end
        if (in_vld === 1'b1) begin
            core_res     = sha_compress(in_hash, chunk);
            core_busy    = 1;
            core_lat_cnt = $urandom_range(core_lat_min, core_lat_max);
            pulse_cnt++;
            chunk_log.push_back(chunk);
        end
    end

    task automatic send_msg(input bytes_t msg, input int max_gap);
        int  t;
        bit  ok;
        exp_q.push_back(sha256_model(msg));
        @(posedge clk); #1;
        for (int i = 0; i < msg.size(); i++) begin
            s_valid = 1'b0;
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
            end
            s_data  = msg[i];
            s_last  = (i == msg.size() - 1);
            s_valid = 1'b1;
            t  = 0;
            ok = 0;
            while (!ok && t < 5000) begin
                @(negedge clk);
                ok = (s_ready === 1'b1);
                @(posedge clk); #1;
                t++;
            end
            if (!ok) begin
                n_vec++; n_err++;
                $display("FAIL byte_accept_timeout: byte %0d never accepted, s_ready=%b required 1", i, s_ready);
                s_valid = 1'b0; s_last = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic recv_digest(input int hold);
        int           t;
        logic [255:0] exp, held;
        t = 0;
        @(negedge clk);
        while (m_valid !== 1'b1 && t < 8000) begin @(negedge clk); t++; end
        n_vec++;
        if (m_valid !== 1'b1) begin
            n_err++;
            $display("FAIL digest_timeout: m_valid=%b required 1", m_valid);
            return;
        end
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: digest %h arrived, required none", m_digest);
            return;
        end
        exp = exp_q.pop_front();
        got_digest = m_digest;
        n_vec++;
        if (m_digest !== exp) begin
            n_err++;
            $display("FAIL digest: got %h required %h", m_digest, exp);
        end
        held = m_digest;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_vec++;
            if (m_valid !== 1'b1 || m_digest !== held || s_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold: cycle %0d m_valid=%b s_ready=%b digest=%h required 1/0/%h", i, m_valid, s_ready, m_digest, held);
            end
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        n_vec++;
        if (m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL m_valid_clear: m_valid=%b required 0", m_valid);
        end
    endtask

    task automatic test_reset;
        #1;
        n_vec++;
        if (s_ready !== 1'b0 || in_vld !== 1'b0 || m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: s_ready=%b in_vld=%b m_valid=%b required 0/0/0", s_ready, in_vld, m_valid);
        end
        n_vec++;
        if (chunk !== 512'd0 || m_digest !== 256'd0) begin
            n_err++;
            $display("FAIL reset_data: chunk=%h m_digest=%h required zeros", chunk, m_digest);
        end
        n_vec++;
        if (in_hash !== IV) begin
            n_err++;
            $display("FAIL reset_iv: in_hash=%h required %h", in_hash, IV);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: s_ready=%b required 1", s_ready);
        end
    endtask

    task automatic test_abc;
        int p0, c0;
        p0 = pulse_cnt; c0 = chunk_log.size();
        send_msg(str_msg("abc"), 0);
        recv_digest(0);
        n_vec++;
        if (got_digest !== 256'hf20015adb410ff6196177a9cb00361a35dae2223414140de8f01cfeaba7816bf) begin
            n_err++;
            $display("FAIL abc_kat: got %h required f20015ad..ba7816bf", got_digest);
        end
        n_vec++;
        if (pulse_cnt - p0 !== 1) begin
            n_err++;
            $display("FAIL abc_pulses: got %0d required 1", pulse_cnt - p0);
        end else begin
            n_vec++;
            if (chunk_log[c0][31:0] !== 32'h61626380 || chunk_log[c0][511:480] !== 32'h00000018) begin
                n_err++;
                $display("FAIL abc_chunk: W0=%h W15=%h required 61626380/00000018", chunk_log[c0][31:0], chunk_log[c0][511:480]);
            end
        end
    endtask

    task automatic test_56;
        int p0, c0;
        p0 = pulse_cnt; c0 = chunk_log.size();
        send_msg(str_msg("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), 1);
        recv_digest(0);
        n_vec++;
        if (got_digest !== {32'h19db06c1, 32'hf6ecedd4, 32'h64ff2167, 32'ha33ce459,
                            32'h0c3e6039, 32'he5c02693, 32'hd20638b8, 32'h248d6a61}) begin
            n_err++;
            $display("FAIL b56_kat: got %h", got_digest);
        end
        n_vec++;
        if (pulse_cnt - p0 !== 2) begin
            n_err++;
            $display("FAIL b56_pulses: got %0d required 2", pulse_cnt - p0);
        end else begin
            n_vec++;
            if (chunk_log[c0+1][31:0] !== 32'h0 || chunk_log[c0+1][511:480] !== 32'h000001c0) begin
                n_err++;
                $display("FAIL b56_chunk2: W0=%h W15=%h required 00000000/000001c0", chunk_log[c0+1][31:0], chunk_log[c0+1][511:480]);
            end
        end
    endtask

    task automatic test_boundaries;
        int lens [7] = '{55, 56, 63, 64, 65, 119, 120};
        int p0, req;
        for (int k = 0; k < 7; k++) begin
            p0  = pulse_cnt;
            req = (lens[k] + 8) / 64 + 1;
            send_msg(rand_msg(lens[k]), 0);
            recv_digest(0);
            n_vec++;
            if (pulse_cnt - p0 !== req) begin
                n_err++;
                $display("FAIL boundary_pulses: len %0d got %0d required %0d", lens[k], pulse_cnt - p0, req);
            end
        end
    endtask

    task automatic test_backpressure;
        send_msg(str_msg("abc"), 0);
        recv_digest(20);
        send_msg(rand_msg(30), 0);
        recv_digest(0);
    endtask

    task automatic test_back_to_back;
        core_lat_max = 6;
        fork
            begin
                for (int m = 0; m < 10; m++) send_msg(rand_msg($urandom_range(1, 200)), 3);
            end
            begin
                for (int m = 0; m < 10; m++) recv_digest($urandom_range(0, 5));
            end
        join
        core_lat_max = 3;
    endtask

    task automatic test_reset_in_wait;
        int t;
        int p0;
        core_lat_min = 10;
        core_lat_max = 10;
        p0 = pulse_cnt;
        send_msg(rand_msg(100), 0);
        void'(exp_q.pop_front());
        t = 0;
        while (pulse_cnt - p0 < 2 && t < 2000) begin @(negedge clk); t++; end
        n_vec++;
        if (pulse_cnt - p0 < 2) begin
            n_err++;
            $display("FAIL rst_wait_reach: pulses %0d required 2", pulse_cnt - p0);
        end
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (in_vld !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b0 || chunk !== 512'd0 || in_hash !== IV) begin
            n_err++;
            $display("FAIL rst_wait_immediate: in_vld=%b s_ready=%b m_valid=%b chunk_zero=%b iv=%b required 0/0/0/1/1",
                     in_vld, s_ready, m_valid, chunk == 512'd0, in_hash == IV);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        while (core_busy && t < 100) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        n_vec++;
        if (in_hash !== IV || m_valid !== 1'b0 || s_ready !== 1'b1 || in_vld !== 1'b0) begin
            n_err++;
            $display("FAIL rst_late_outvld: in_hash=%h m_valid=%b s_ready=%b in_vld=%b required IV/0/1/0", in_hash, m_valid, s_ready, in_vld);
        end
        core_lat_min = 0;
        core_lat_max = 3;
        send_msg(str_msg("abc"), 0);
        recv_digest(0);
    endtask

    initial begin
        rst_n    = 1'b0;
        s_data   = 8'h00;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        m_ready  = 1'b0;
        out_vld  = 1'b0;
        out_hash = '0;
        repeat (3) @(posedge clk);
        test_reset;
        test_abc;
        test_56;
        test_boundaries;
        test_backpressure;
        test_back_to_back;
        test_reset_in_wait;
        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sha256_msg_ctrl.md
Name: sha256_msg_ctrl

Overview:
- Front-end controller that turns a byte-stream message into padded 512-bit chunks, drives the sha256 core's chunk/in_hash/in_vld inputs, and chains the core's out_hash/out_vld back in for each next block.
- Sits in front of sha256, which is the responder. Handles one message at a time with one block outstanding.
- Presents the final 256-bit digest on a valid/ready output.

Parameters:
- LEN_W, 32, width of the message byte counter. Maximum message length is 2^LEN_W-1 bytes.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- s_data  in  8  message byte
- s_valid  in  1  s_data valid
- s_last  in  1  marks the final byte of a message (messages are at least 1 byte)
- s_ready  out  1  controller accepts a byte
- chunk  out  512  to core; word Wi at [32i+31:32i], big-endian within the word (first byte of the block at [31:24])
- in_hash  out  256  to core; Hi at [32i+31:32i]
- in_vld  out  1  to core; one-cycle pulse per block
- out_hash  in  256  from core; same layout as in_hash
- out_vld  in  1  from core; result valid
- m_digest  out  256  final hash; same layout as in_hash
- m_valid  out  1  digest valid
- m_ready  in  1  digest accepted

Behaviour:
- Reset (async, rst_n=0):
  - state=FILL, byte index=0, byte count=0.
  - chunk=0, in_vld=0, m_valid=0, m_digest=0, s_ready=0.
  - H register = IV (256'h5be0cd19..6a09e667, H0=6a09e667 in the LSBs).
  - Deassertion takes effect on the next rising edge. Asserting reset mid-message discards everything; any core result still in flight is ignored.
- Byte transfer: occurs on a clk edge with s_valid && s_ready. s_ready=1 only in FILL. Bytes are written into the block buffer at index idx (0..63), idx increments, and the LEN_W byte counter increments, wrapping mod 2^LEN_W.
- States:
  - FILL: accepting bytes.
  - SEND: in_vld=1 for exactly 1 cycle. chunk = block buffer, in_hash = H.
  - WAIT: in_vld=0; chunk and in_hash are held stable until out_vld.
  - PAD2: build the extra padding block.
  - OUT: present the digest.
- Transitions out of FILL, where n is the number of bytes in the block after the accepted byte:
  - Byte with s_last=0 and n=64: go to SEND. Block is non-final. idx resets to 0 after SEND.
  - s_last=1 and n<=55: byte n=0x80, bytes n+1..55=0, bytes 56..63 = bit length (count*8 zero-extended to 64 bits, big-endian). Go to SEND, marked final.
  - s_last=1 and 56<=n<=63: byte n=0x80, remaining bytes=0. Go to SEND, non-final, set pad_pending with pad_80=0.
  - s_last=1 and n=64: go to SEND, non-final, set pad_pending with pad_80=1.
- WAIT on out_vld: H <= out_hash. Then:
  - if final, go to OUT;
  - else if pad_pending, go to PAD2;
  - else go to FILL.
- PAD2 (1 cycle): buffer = zeros, byte0=0x80 if pad_80, length in bytes 56..63. Then go to SEND, marked final.
- OUT: m_valid=1 and m_digest=H, both held until m_valid&&m_ready. On that handshake: H <= IV, count=0, idx=0, m_valid=0, go to FILL. s_ready=0 throughout OUT (digest backpressure stalls input).
- out_vld outside WAIT is ignored. s_valid is ignored when s_ready=0.
- Latency: first s_ready after the last byte is accepted = blocks×(core latency+2)+1 cycles. in_vld rises 1 cycle after the block-completing byte is accepted.

Test Plan:
- "abc" (3 bytes, s_last on 'c') -> exactly one in_vld pulse; chunk W0=61626380, W15=00000018; m_digest = f20015ad_b410ff61_96177a9c_b00361a3_5dae2223_414140de_8f01cfea_ba7816bf (MSW..LSW).
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> two in_vld pulses, second chunk has W0=0, W15=000001c0; digest H0..H7 = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Block-size boundary lengths: 55, 56, 63, 64, 65, 119, 120 random bytes -> in_vld pulse counts 1, 2, 2, 2, 2, 2, 3; digests match the software SHA256 model.
- Backpressure: hold m_ready=0 for 20 cycles after "abc" -> m_valid and m_digest stable, s_ready=0; release -> next message starts from IV and digests correctly.
- Random s_valid gaps plus 10 back-to-back messages of random length 1..200 -> all digests match the model, in order.
- Reset pulse asserted while in WAIT of the second block of a 100-byte message -> outputs take their reset values immediately, the late out_vld is ignored, and a subsequent "abc" digest is correct.
